// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word fall-through head,
// occupancy status and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        pop, push, drop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign pop  = rd_en && !empty;
    assign push = wr_valid && (!full || pop);
    assign drop = wr_valid && full && !pop;

    assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed test-plan steps plus a random phase, all checked
// against a queue-based model of the FIFO contents and the overflow flag.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_ovf;

    int            nCompared;
    int            nMismatched;
    logic [7:0]    modelQ [$];
    logic          modelOvf;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus, driven from a falling edge; the model advances at the rising edge.
    task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic re, input logic co);
        bit wasFull;
        bit doPop;
        bit doDrop;
        wr_valid = wv;
        wr_data  = wd;
        rd_en    = re;
        clr_ovf  = co;
        @(posedge clk);
        wasFull = (modelQ.size() == DEPTH);
        doPop   = re && (modelQ.size() != 0);
        doDrop  = wv && wasFull && !doPop;
        if (doPop) void'(modelQ.pop_front());
        if (wv && !doDrop) modelQ.push_back(wd);
        if (doDrop) modelOvf = 1'b1;
        else if (co) modelOvf = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0]  expData;
        logic [AW:0] expCount;
        expData  = (modelQ.size() != 0) ? modelQ[0] : 8'h00;
        expCount = (AW+1)'(modelQ.size());
        nCompared++;
        assert (count === expCount) else begin
            nMismatched++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, count, expCount);
        end
        nCompared++;
        assert (empty === (modelQ.size() == 0)) else begin
            nMismatched++;
            $error("[TB] FAIL %s empty: observed %b expected %b", tag, empty, modelQ.size() == 0);
        end
        nCompared++;
        assert (full === (modelQ.size() == DEPTH)) else begin
            nMismatched++;
            $error("[TB] FAIL %s full: observed %b expected %b", tag, full, modelQ.size() == DEPTH);
        end
        nCompared++;
        assert (overflow === modelOvf) else begin
            nMismatched++;
            $error("[TB] FAIL %s overflow: observed %b expected %b", tag, overflow, modelOvf);
        end
        nCompared++;
        assert (rd_data === expData) else begin
            nMismatched++;
            $error("[TB] FAIL %s rd_data: observed %02h expected %02h", tag, rd_data, expData);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        modelOvf    = 1'b0;
        rst         = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = 8'h00;
        rd_en       = 1'b0;
        clr_ovf     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("reset");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, i[0], 1'b0);
            checkOutput("idle");
        end

        applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
        checkOutput("single_push");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("single_pop");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("fill");
        end
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("drop_ff");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain");
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_ovf");

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            checkOutput("refill");
        end
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("full_push_pop");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("drain_aa");
        end

        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
        checkOutput("empty_push_pop");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop_bb");

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'h80 + 8'(i), i >= 2, 1'b0);
            checkOutput("wrap");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wrap_drain");
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            checkOutput("wrap_fill");
        end
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        checkOutput("drop_with_clr");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_alone");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wrap_empty");
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
            checkOutput("pre_reset");
        end
        #2 rst = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        #1 checkOutput("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("after_reset");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("push_5a");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 60), 8'($urandom),
                          ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the `uart` block. It captures each byte the UART receiver strobes out on `o_ready`/`o_data`, holds up to `DEPTH` bytes, and presents them to the CPU-side reader as a first-word-fall-through queue. It also provides occupancy status and a sticky overflow flag. This decouples CPU polling latency from the serial byte rate.

## Interface
Parameters:
- `DEPTH`, default 16: number of byte slots; must be a power of two, ≥ 2.
- `AW`, default 4: address width, equal to log2(DEPTH).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: one clock; reset is asynchronous and active-low. All state clears immediately while `rst`=0.
- `wr_valid`, in, 1: one-cycle byte strobe, driven by the UART `o_ready`.
- `wr_data`, in, 8: received byte, driven by the UART `o_data`. Sampled only when `wr_valid`=1.
- `rd_en`, in, 1: pop request from the reader.
- `rd_data`, out, 8: head byte, first-word fall-through. Reads 8'h00 while `empty`=1.
- `empty`, out, 1: no bytes buffered.
- `full`, out, 1: `count` == DEPTH.
- `count`, out, AW+1: number of buffered bytes, 0..DEPTH.
- `overflow`, out, 1: sticky; set when a byte is dropped.
- `clr_ovf`, in, 1: clears `overflow`.

## Operation
- Storage: DEPTH×8 register array, written only at `wr_ptr`.
- Pointers: `wr_ptr` and `rd_ptr` are each AW+1 bits; the low AW bits index the array and the MSB is the wrap bit.
  - `count` = `wr_ptr` − `rd_ptr`, modulo 2^(AW+1).
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = low AW bits equal and MSBs differ.
- Push condition: `wr_valid` && (!`full` || `pop`). On push, `mem[wr_ptr]` ← `wr_data` and `wr_ptr` increments.
- Pop condition: `pop` = `rd_en` && !`empty`. On pop, `rd_ptr` increments. `rd_en` while empty is ignored with no side effect.
- Simultaneous push and pop:
  - When not empty: both occur and `count` is unchanged.
  - When full: both occur, the byte is accepted, `full` stays 1, and `overflow` is not set.
  - When empty: the pop is ignored and the push occurs.
- Drop: `wr_valid` && `full` && !`pop` discards `wr_data`. Storage and pointers are unchanged, and `overflow` ← 1.
- `overflow` clears on `clr_ovf`=1. If a drop and `clr_ovf` happen in the same cycle, set wins (`overflow` stays 1).
- Pointer wrap: after DEPTH pushes, `wr_ptr` low bits return to 0 and the MSB toggles. The buffer is seamless across the wrap with no lost or duplicated byte.
- No internal state machine beyond the pointers and the flag. The block is stateless with respect to serial framing.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `wr_ptr`=0, `rd_ptr`=0
  - `empty`=1, `full`=0, `count`=0
  - `overflow`=0, `rd_data`=8'h00
- Array contents are not reset.
- Reset mid-operation discards all buffered bytes. The first strobe after `rst` rises is stored at slot 0.
- Write latency: a strobe in cycle N gives, from cycle N+1, `empty`=0, an incremented `count`, and the byte on `rd_data` if the FIFO was empty.
- Read: `rd_data` is valid in the same cycle that `empty`=0, with no read latency. A pop in cycle N advances `rd_data` to the next byte (or 8'h00 if the FIFO became empty) from cycle N+1.
- `full`, `empty`, `count` and `overflow` are derived from registers and update only on clock edges. There are no combinational paths from `wr_valid` or `rd_en` to any output.
- Back-to-back strobes on consecutive cycles are all accepted while space remains. The bench drives `wr_valid` at one-cycle width, matching UART `o_ready`.
- `clr_ovf` takes effect at the next edge, so `overflow`=0 from cycle N+1.

## Test plan
- Reset then idle: drive `rst`=0 for 2 cycles, then release → `empty`=1, `full`=0, `count`=0, `overflow`=0, `rd_data`=8'h00, stable for 10 cycles with `rd_en` toggling.
- Single byte: strobe 8'h41 in cycle N → at N+1, `empty`=0, `count`=1, `rd_data`=8'h41. Pop at N+2 → at N+3, `empty`=1, `rd_data`=8'h00.
- Fill and overflow (DEPTH=16):
  - Strobe 8'h00..8'h0F → `full`=1, `count`=16, `overflow`=0.
  - Strobe 8'hFF → `overflow`=1, `count`=16.
  - Pop 16 times → read 8'h00..8'h0F in order with no 8'hFF.
- Simultaneous push and pop:
  - At `count`=16, strobe 8'hAA with `rd_en` → `count` stays 16, `overflow`=0. 8'hAA is read last, after the 15 remaining bytes.
  - At `count`=0, strobe 8'hBB with `rd_en` → `count`=1, `rd_data`=8'hBB.
- Wrap-around: push and pop 40 bytes (8'h80+i) keeping `count` ≤ 3 → every byte is read in order and the pointers wrap twice. Then drop a byte at full while asserting `clr_ovf` in the same cycle → `overflow`=1. Assert `clr_ovf` alone → `overflow`=0.
- Reset mid-operation: with `count`=5, pull `rst` low asynchronously between edges → outputs immediately return to reset values. After release, strobe 8'h5A → `rd_data`=8'h5A, `count`=1.
